// File: rtl/dfe_cfg_pkg.sv
// Shared types and helpers for the DFE configuration sequencer: state encoding,
// legal CIC decimation factors and factor arithmetic.
package dfe_cfg_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_DRAIN,
    ST_FLUSH,
    ST_LOAD,
    ST_SETTLE
  } seq_state_e;

  localparam logic [4:0] FACTOR_1  = 5'd1;
  localparam logic [4:0] FACTOR_2  = 5'd2;
  localparam logic [4:0] FACTOR_4  = 5'd4;
  localparam logic [4:0] FACTOR_8  = 5'd8;
  localparam logic [4:0] FACTOR_16 = 5'd16;

  function automatic logic factor_is_legal(input logic [4:0] factor);
    return factor inside {FACTOR_1, FACTOR_2, FACTOR_4, FACTOR_8, FACTOR_16};
  endfunction

  // Only meaningful for legal factors; anything else maps to 0.
  function automatic logic [2:0] factor_log2(input logic [4:0] factor);
    logic [2:0] result;
    result = 3'd0;
    case (factor)
      FACTOR_2:  result = 3'd1;
      FACTOR_4:  result = 3'd2;
      FACTOR_8:  result = 3'd3;
      FACTOR_16: result = 3'd4;
      default:   result = 3'd0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dfe_seq_down_counter.sv
// Loadable down-counter that stops at zero; shared by the flush, settle and
// drain-timeout phases of the configuration sequencer.
module dfe_seq_down_counter #(
  parameter int W         = 9,
  parameter int RESET_VAL = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero,
  output logic         o_one
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_count <= W'(RESET_VAL);
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);
  assign o_one  = (r_count == W'(1));

endmodule

// File: rtl/dfe_cfg_sequencer.sv
// Glitch-free run-time reconfiguration of the DFE chain: stop, drain, flush, load,
// settle, release. Optional drain timeout is enabled by defining DFE_SEQ_TIMEOUT_EN.
module dfe_cfg_sequencer
  import dfe_cfg_pkg::*;
#(
  parameter int FLUSH_CYCLES   = 8,
  parameter int SETTLE_BASE    = 16,
  parameter int RESET_FACTOR   = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cfg_req,
  input  logic [4:0] cfg_factor,
  input  logic       cfg_enable,
  input  logic       dp_idle,
  output logic       cfg_ack,
  output logic       cfg_err,
  output logic       busy,
  output logic [4:0] CIC_Decimation_Factor,
  output logic       filter_enable,
  output logic       stage_flush,
  output logic       out_gate
);

  localparam int SETTLE_W = $clog2(SETTLE_BASE * 16 + 1);
  localparam int FLUSH_W  = $clog2(FLUSH_CYCLES + 1);
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SF_W     = (SETTLE_W > FLUSH_W) ? SETTLE_W : FLUSH_W;
  localparam int CNT_W    = (SF_W > TMO_W) ? SF_W : TMO_W;

  seq_state_e r_state;
  logic [4:0] r_factor;
  logic [4:0] r_shadow_factor;
  logic       r_shadow_enable;
  logic       r_filter_enable;
  logic       r_stage_flush;
  logic       r_out_gate;
  logic       r_busy;
  logic       r_ack;
  logic       r_err;
  logic       r_armed;
  logic       r_req_seq;
  logic       r_tmo_flag;

  logic             w_legal;
  logic             w_same;
  logic             w_accept;
  logic             w_start;
  logic             w_timeout;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_dec;
  logic             w_cnt_zero;
  logic             w_cnt_one;

  assign w_legal  = factor_is_legal(cfg_factor);
  assign w_same   = (cfg_factor == r_factor) && (cfg_enable == r_filter_enable);
  // A request is taken only in RUN and only after cfg_req has been seen low.
  assign w_accept = (r_state == ST_RUN) && cfg_req && r_armed;
  assign w_start  = w_accept && w_legal && !w_same;

`ifdef DFE_SEQ_TIMEOUT_EN
  assign w_timeout = (r_state == ST_DRAIN) && !dp_idle && w_cnt_one;
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      ST_RUN: begin
`ifdef DFE_SEQ_TIMEOUT_EN
        if (w_start) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = CNT_W'(TIMEOUT_CYCLES);
        end
`endif
      end
      ST_DRAIN: begin
        if (dp_idle || w_timeout) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = CNT_W'(FLUSH_CYCLES);
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_FLUSH:  w_cnt_dec = 1'b1;
      ST_LOAD: begin
        w_cnt_load = 1'b1;
        w_cnt_val  = CNT_W'(SETTLE_BASE) << factor_log2(r_shadow_factor);
      end
      ST_SETTLE: w_cnt_dec = 1'b1;
      default:   w_cnt_dec = 1'b0;
    endcase
  end

  dfe_seq_down_counter #(
    .W        (CNT_W),
    .RESET_VAL(FLUSH_CYCLES)
  ) u_counter (
    .CLK       (CLK),
    .RST       (RST),
    .i_load    (w_cnt_load),
    .i_load_val(w_cnt_val),
    .i_dec     (w_cnt_dec),
    .o_zero    (w_cnt_zero),
    .o_one     (w_cnt_one)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state         <= ST_FLUSH;
      r_factor        <= 5'(RESET_FACTOR);
      r_shadow_factor <= 5'(RESET_FACTOR);
      r_shadow_enable <= 1'b1;
      r_filter_enable <= 1'b0;
      r_stage_flush   <= 1'b0;
      r_out_gate      <= 1'b0;
      r_busy          <= 1'b1;
      r_ack           <= 1'b0;
      r_err           <= 1'b0;
      r_armed         <= 1'b1;
      r_req_seq       <= 1'b0;
      r_tmo_flag      <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (!cfg_req) r_armed <= 1'b1;

      case (r_state)
        ST_RUN: begin
          if (w_accept) begin
            r_armed <= 1'b0;
            if (!w_legal) begin
              r_ack <= 1'b1;
              r_err <= 1'b1;
            end else if (w_same) begin
              r_ack <= 1'b1;
            end else begin
              r_shadow_factor <= cfg_factor;
              r_shadow_enable <= cfg_enable;
              r_filter_enable <= 1'b0;
              r_out_gate      <= 1'b0;
              r_busy          <= 1'b1;
              r_req_seq       <= 1'b1;
              r_tmo_flag      <= 1'b0;
              r_state         <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (dp_idle || w_timeout) begin
            if (w_timeout) r_tmo_flag <= 1'b1;
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_cnt_zero) begin
            r_stage_flush <= 1'b0;
            r_state       <= ST_LOAD;
          end else begin
            r_stage_flush <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_factor        <= r_shadow_factor;
          r_filter_enable <= r_shadow_enable;
          r_state         <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Leave as the counter reaches zero so settle lasts SETTLE_BASE*factor cycles.
          if (w_cnt_one) begin
            r_out_gate <= 1'b1;
            r_busy     <= 1'b0;
            r_ack      <= r_req_seq;
            r_err      <= r_req_seq && r_tmo_flag;
            r_req_seq  <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        default: r_state <= ST_FLUSH;
      endcase
    end
  end

  assign cfg_ack               = r_ack;
  assign cfg_err               = r_err;
  assign busy                  = r_busy;
  assign CIC_Decimation_Factor = r_factor;
  assign filter_enable         = r_filter_enable;
  assign stage_flush           = r_stage_flush;
  assign out_gate              = r_out_gate;

endmodule

// File: tb/tb_dfe_cfg_sequencer.sv
// Self-checking bench for dfe_cfg_sequencer: timeline reference model compared every
// cycle, directed scenarios with literal expectations, then randomized requests.
module tb_dfe_cfg_sequencer;

  localparam int FLUSH_CYCLES   = 8;
  localparam int SETTLE_BASE    = 16;
  localparam int RESET_FACTOR   = 1;
  localparam int TIMEOUT_CYCLES = 1024;
`ifdef DFE_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       cfg_req = 1'b0;
  logic [4:0] cfg_factor = 5'd1;
  logic       cfg_enable = 1'b1;
  logic       dp_idle = 1'b1;
  logic       cfg_ack, cfg_err, busy, filter_enable, stage_flush, out_gate;
  logic [4:0] CIC_Decimation_Factor;

  always #5 CLK = ~CLK;

  dfe_cfg_sequencer #(
    .FLUSH_CYCLES  (FLUSH_CYCLES),
    .SETTLE_BASE   (SETTLE_BASE),
    .RESET_FACTOR  (RESET_FACTOR),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .cfg_req              (cfg_req),
    .cfg_factor           (cfg_factor),
    .cfg_enable           (cfg_enable),
    .dp_idle              (dp_idle),
    .cfg_ack              (cfg_ack),
    .cfg_err              (cfg_err),
    .busy                 (busy),
    .CIC_Decimation_Factor(CIC_Decimation_Factor),
    .filter_enable        (filter_enable),
    .stage_flush          (stage_flush),
    .out_gate             (out_gate)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input int f);
    return (f == 1) || (f == 2) || (f == 4) || (f == 8) || (f == 16);
  endfunction

  // Reference model: a request either completes at once or opens a timeline whose
  // origin is the edge the flush phase begins (the reset edge after a reset).
  typedef enum int {M_RUN, M_DRAIN, M_TIMED} mphase_e;
  mphase_e m_mode;
  bit m_valid = 1'b0;
  int m_factor, m_sh_f, m_t, m_dcnt;
  bit m_en, m_flush, m_gate, m_ack, m_err, m_busy, m_sh_en, m_req_seq, m_armed, m_tmo;

  always @(posedge CLK) begin : model
    bit acc;
    if (!RST) begin
      m_factor = RESET_FACTOR; m_sh_f = RESET_FACTOR; m_sh_en = 1'b1;
      m_en = 1'b0; m_flush = 1'b0; m_gate = 1'b0; m_ack = 1'b0; m_err = 1'b0;
      m_busy = 1'b1; m_req_seq = 1'b0; m_armed = 1'b1; m_tmo = 1'b0;
      m_mode = M_TIMED; m_t = 0;
    end else begin
      m_ack = 1'b0;
      m_err = 1'b0;
      acc = (m_mode == M_RUN) && cfg_req && m_armed;
      if (!cfg_req) m_armed = 1'b1;
      if (acc) m_armed = 1'b0;
      case (m_mode)
        M_RUN: if (acc) begin
          if (!legal(int'(cfg_factor))) begin
            m_ack = 1'b1; m_err = 1'b1;
          end else if (int'(cfg_factor) == m_factor && cfg_enable == m_en) begin
            m_ack = 1'b1;
          end else begin
            m_sh_f = int'(cfg_factor); m_sh_en = cfg_enable;
            m_en = 1'b0; m_gate = 1'b0; m_busy = 1'b1;
            m_req_seq = 1'b1; m_tmo = 1'b0; m_dcnt = 0; m_mode = M_DRAIN;
          end
        end
        M_DRAIN: begin
          m_dcnt++;
          if (dp_idle) begin
            m_mode = M_TIMED; m_t = 0;
          end else if (TMO_EN && m_dcnt == TIMEOUT_CYCLES) begin
            m_tmo = 1'b1; m_mode = M_TIMED; m_t = 0;
          end
        end
        default: begin
          m_t++;
          m_flush = (m_t >= 1) && (m_t <= FLUSH_CYCLES);
          if (m_t == FLUSH_CYCLES + 2) begin
            m_factor = m_sh_f; m_en = m_sh_en;
          end
          if (m_t == FLUSH_CYCLES + 2 + SETTLE_BASE * m_sh_f) begin
            m_gate = 1'b1; m_busy = 1'b0; m_mode = M_RUN;
            m_ack = m_req_seq; m_err = m_req_seq && m_tmo; m_req_seq = 1'b0;
          end
        end
      endcase
    end
    m_valid = 1'b1;
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      check("factor", 32'(CIC_Decimation_Factor), 32'(m_factor));
      check("filter_enable", 32'(filter_enable), 32'(m_en));
      check("stage_flush", 32'(stage_flush), 32'(m_flush));
      check("out_gate", 32'(out_gate), 32'(m_gate));
      check("busy", 32'(busy), 32'(m_busy));
      check("cfg_ack", 32'(cfg_ack), 32'(m_ack));
      check("cfg_err", 32'(cfg_err), 32'(m_ack & m_err));
    end
  end

  bit rand_idle = 1'b0;

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_idle) dp_idle = ($urandom_range(0, 9) < 7);
  endtask

  task automatic request(input int f, input bit en);
    cfg_factor = 5'(f);
    cfg_enable = en;
    cfg_req    = 1'b1;
  endtask

  // n = edges between the edge that samples the request and the edge raising cfg_ack.
  task automatic wait_ack(input int limit, output int n, output bit err, output int nflush,
                          output bit got);
    n = 0; err = 1'b0; nflush = 0; got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (stage_flush) nflush++;
      if (cfg_ack) begin
        got = 1'b1;
        err = cfg_err;
        break;
      end
      n++;
    end
  endtask

  // n = edges after the last reset edge until out_gate is seen high.
  task automatic wait_gate(output int n, output int nflush, output int nack);
    n = 0; nflush = 0; nack = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      n++;
      if (stage_flush) nflush++;
      if (cfg_ack) nack++;
      if (out_gate) break;
    end
  endtask

  initial begin : main
    int n, nflush, nack, acks;
    bit err, got;

    repeat (3) tick();
    check("reset_factor", 32'(CIC_Decimation_Factor), 32'd1);
    check("reset_out_gate", 32'(out_gate), 32'd0);
    check("reset_filter_enable", 32'(filter_enable), 32'd0);
    RST = 1'b1;
    wait_gate(n, nflush, nack);
    check("post_reset_gate_delay", n, 32'd26);
    check("post_reset_flush_len", nflush, 32'd8);
    check("post_reset_no_ack", nack, 32'd0);
    check("post_reset_factor", 32'(CIC_Decimation_Factor), 32'd1);
    check("post_reset_enable", 32'(filter_enable), 32'd1);

    // factor 4: 1 + 1 + 8 + 1 + 64 edges
    request(4, 1'b1);
    wait_ack(500, n, err, nflush, got);
    check("f4_ack_seen", got, 32'd1);
    check("f4_latency", n, 32'd75);
    check("f4_err", err, 32'd0);
    check("f4_flush_len", nflush, 32'd8);
    check("f4_factor", 32'(CIC_Decimation_Factor), 32'd4);
    cfg_req = 1'b0;
    tick();

    request(3, 1'b0);
    wait_ack(50, n, err, nflush, got);
    check("illegal_ack_seen", got, 32'd1);
    check("illegal_latency", n, 32'd0);
    check("illegal_err", err, 32'd1);
    check("illegal_no_flush", nflush, 32'd0);
    check("illegal_factor_kept", 32'(CIC_Decimation_Factor), 32'd4);
    check("illegal_gate_kept", 32'(out_gate), 32'd1);
    cfg_req = 1'b0;
    tick();

    request(4, 1'b1);
    wait_ack(50, n, err, nflush, got);
    check("same_ack_seen", got, 32'd1);
    check("same_latency", n, 32'd0);
    check("same_err", err, 32'd0);
    acks = 0;
    repeat (20) begin
      tick();
      if (cfg_ack) acks++;
    end
    check("held_req_no_reack", acks, 32'd0);
    cfg_req = 1'b0;
    tick();
    request(4, 1'b1);
    wait_ack(50, n, err, nflush, got);
    check("retoggle_ack", got, 32'd1);
    cfg_req = 1'b0;
    tick();

    dp_idle = 1'b0;
    request(2, 1'b0);
    wait_ack(2000, n, err, nflush, got);
`ifdef DFE_SEQ_TIMEOUT_EN
    check("tmo_ack_seen", got, 32'd1);
    check("tmo_latency", n, 32'd1066);
    check("tmo_err", err, 32'd1);
    check("tmo_factor", 32'(CIC_Decimation_Factor), 32'd2);
    dp_idle = 1'b1;
`else
    check("drain_no_ack", got, 32'd0);
    check("drain_no_flush", nflush, 32'd0);
    check("drain_busy", 32'(busy), 32'd1);
    dp_idle = 1'b1;
    wait_ack(500, n, err, nflush, got);
    check("drain_release_ack", got, 32'd1);
    check("drain_release_latency", n, 32'd42);
    check("drain_release_err", err, 32'd0);
`endif
    cfg_req = 1'b0;
    tick();

    request(16, 1'b1);
    repeat (111) tick();
    check("settle_busy", 32'(busy), 32'd1);
    check("settle_gate_low", 32'(out_gate), 32'd0);
    cfg_req = 1'b0;
    RST = 1'b0;
    tick();
    tick();
    check("midreset_factor", 32'(CIC_Decimation_Factor), 32'd1);
    check("midreset_gate", 32'(out_gate), 32'd0);
    check("midreset_flush", 32'(stage_flush), 32'd0);
    RST = 1'b1;
    wait_gate(n, nflush, nack);
    check("midreset_gate_delay", n, 32'd26);
    check("midreset_flush_len", nflush, 32'd8);
    check("midreset_no_ack", nack, 32'd0);
    check("midreset_final_factor", 32'(CIC_Decimation_Factor), 32'd1);

    rand_idle = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int tbl[10] = '{1, 2, 4, 8, 16, 3, 0, 5, 12, 31};
      request(tbl[$urandom_range(0, 9)], 1'($urandom_range(0, 1)));
      wait_ack(3000, n, err, nflush, got);
      check("rand_ack_seen", got, 32'd1);
      cfg_req = 1'b0;
      repeat ($urandom_range(1, 4)) tick();
    end
    rand_idle = 1'b0;
    dp_idle = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
